// File: rtl/reorder_buffer.sv
// reorder_buffer: circular buffer that captures RS/LSB results, retires in program order and flushes on mispredict.
// Optional ROB_BYPASS_EN: the dependency query also forwards same-cycle RS/LSB results.
module reorder_buffer #(
  parameter int ROB_WIDTH    = 4,
  parameter int ROB_OP_WIDTH = 2
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic                    robAddValid,
  input  logic [ROB_OP_WIDTH-1:0] robAddType,
  input  logic                    robAddReady,
  input  logic [31:0]             robAddValue,
  input  logic [4:0]              robAddDest,
  input  logic [31:0]             robAddAddr,
  input  logic                    robAddJump,
  input  logic                    rsUpdate,
  input  logic [ROB_WIDTH-1:0]    rsRobIndex,
  input  logic [31:0]             rsUpdateVal,
  input  logic                    lsbUpdate,
  input  logic [ROB_WIDTH-1:0]    lsbRobIndex,
  input  logic [31:0]             lsbUpdateVal,
  input  logic [ROB_WIDTH-1:0]    robRequest,
  output logic                    robFull,
  output logic [ROB_WIDTH-1:0]    robNext,
  output logic                    robReady,
  output logic [31:0]             robValue,
  output logic                    regCommitValid,
  output logic [4:0]              regCommitDest,
  output logic [ROB_WIDTH-1:0]    regCommitIndex,
  output logic [31:0]             regCommitValue,
  output logic                    lsbCommitValid,
  output logic [ROB_WIDTH-1:0]    lsbCommitIndex,
  output logic                    predictUpdateValid,
  output logic                    predictTaken,
  output logic [31:0]             predictAddr,
  output logic                    flushOut,
  output logic [31:0]             flushPc
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] CAPACITY   = (ROB_WIDTH+1)'(DEPTH);
  localparam logic [ROB_WIDTH:0] FULL_LEVEL = (ROB_WIDTH+1)'(DEPTH - 2);
  localparam logic [ROB_OP_WIDTH-1:0] OP_REG    = ROB_OP_WIDTH'(0);
  localparam logic [ROB_OP_WIDTH-1:0] OP_BRANCH = ROB_OP_WIDTH'(1);
  localparam logic [ROB_OP_WIDTH-1:0] OP_STORE  = ROB_OP_WIDTH'(2);

  logic [ROB_WIDTH-1:0] headReg;
  logic [ROB_WIDTH-1:0] tailReg;
  logic [ROB_WIDTH:0]   countReg;
  logic [ROB_WIDTH:0]   countNext;

  logic [DEPTH-1:0]                   busyVec;
  logic [DEPTH-1:0]                   readyVec;
  logic [DEPTH-1:0]                   jumpVec;
  logic [DEPTH-1:0][ROB_OP_WIDTH-1:0] typeVec;
  logic [DEPTH-1:0][4:0]              destVec;
  logic [DEPTH-1:0][31:0]             valueVec;
  logic [DEPTH-1:0][31:0]             addrVec;

  logic                    addFire;
  logic                    rsFire;
  logic                    lsbFire;
  logic                    commitFire;
  logic                    mispredict;
  logic                    headTaken;
  logic [ROB_OP_WIDTH-1:0] headType;

  // The cycle in which flushOut is high belongs to the wrong path: its adds and results are dropped.
  assign addFire    = robAddValid && !flushOut && (countReg < CAPACITY);
  assign rsFire     = rsUpdate && !flushOut;
  assign lsbFire    = lsbUpdate && !flushOut;
  assign headType   = typeVec[headReg];
  assign headTaken  = (valueVec[headReg] != 32'd0);
  assign commitFire = !flushOut && busyVec[headReg] && readyVec[headReg];
  assign mispredict = commitFire && (headType == OP_BRANCH) && (headTaken != jumpVec[headReg]);

  always_comb begin
    countNext = countReg;
    case ({addFire, commitFire})
      2'b10:   countNext = countReg + (ROB_WIDTH+1)'(1);
      2'b01:   countNext = countReg - (ROB_WIDTH+1)'(1);
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn || mispredict) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
    end else begin
      if (addFire)    tailReg <= tailReg + ROB_WIDTH'(1);
      if (commitFire) headReg <= headReg + ROB_WIDTH'(1);
      countReg <= countNext;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    logic                    busyReg;
    logic                    readyReg;
    logic                    jumpReg;
    logic [ROB_OP_WIDTH-1:0] typeReg;
    logic [4:0]              destReg;
    logic [31:0]             valueReg;
    logic [31:0]             addrReg;
    logic                    rsHit;
    logic                    lsbHit;

    assign rsHit  = rsFire && (rsRobIndex == ROB_WIDTH'(gi)) && busyReg;
    assign lsbHit = lsbFire && (lsbRobIndex == ROB_WIDTH'(gi)) && busyReg;

    always_ff @(posedge clockIn) begin
      if (resetIn) begin
        busyReg  <= 1'b0;
        readyReg <= 1'b0;
        jumpReg  <= 1'b0;
        typeReg  <= '0;
        destReg  <= '0;
        valueReg <= '0;
        addrReg  <= '0;
      end else if (mispredict) begin
        busyReg  <= 1'b0;
        readyReg <= 1'b0;
      end else if (addFire && (tailReg == ROB_WIDTH'(gi))) begin
        busyReg  <= 1'b1;
        readyReg <= robAddReady;
        jumpReg  <= robAddJump;
        typeReg  <= robAddType;
        destReg  <= robAddDest;
        valueReg <= robAddValue;
        addrReg  <= robAddAddr;
      end else begin
        if (commitFire && (headReg == ROB_WIDTH'(gi))) busyReg <= 1'b0;
        // RS takes priority when both units report the same entry.
        if (rsHit) begin
          readyReg <= 1'b1;
          valueReg <= rsUpdateVal;
        end else if (lsbHit) begin
          readyReg <= 1'b1;
          valueReg <= lsbUpdateVal;
        end
      end
    end

    assign busyVec[gi]  = busyReg;
    assign readyVec[gi] = readyReg;
    assign jumpVec[gi]  = jumpReg;
    assign typeVec[gi]  = typeReg;
    assign destVec[gi]  = destReg;
    assign valueVec[gi] = valueReg;
    assign addrVec[gi]  = addrReg;
  end

  always_comb begin
    robReady = readyVec[robRequest];
    robValue = valueVec[robRequest];
`ifdef ROB_BYPASS_EN
    if (rsFire && (rsRobIndex == robRequest) && busyVec[robRequest]) begin
      robReady = 1'b1;
      robValue = rsUpdateVal;
    end else if (lsbFire && (lsbRobIndex == robRequest) && busyVec[robRequest]) begin
      robReady = 1'b1;
      robValue = lsbUpdateVal;
    end
`endif
  end

  assign robNext = tailReg;
  assign robFull = (countReg >= FULL_LEVEL);

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      regCommitValid     <= 1'b0;
      regCommitDest      <= '0;
      regCommitIndex     <= '0;
      regCommitValue     <= '0;
      lsbCommitValid     <= 1'b0;
      lsbCommitIndex     <= '0;
      predictUpdateValid <= 1'b0;
      predictTaken       <= 1'b0;
      predictAddr        <= '0;
      flushOut           <= 1'b0;
      flushPc            <= '0;
    end else begin
      regCommitValid     <= commitFire && (headType == OP_REG);
      lsbCommitValid     <= commitFire && (headType == OP_STORE);
      predictUpdateValid <= commitFire && (headType == OP_BRANCH);
      flushOut           <= mispredict;
      if (commitFire && (headType == OP_REG)) begin
        regCommitDest  <= destVec[headReg];
        regCommitIndex <= headReg;
        regCommitValue <= valueVec[headReg];
      end
      if (commitFire && (headType == OP_STORE)) lsbCommitIndex <= headReg;
      if (commitFire && (headType == OP_BRANCH)) begin
        predictTaken <= headTaken;
        predictAddr  <= addrVec[headReg];
      end
      if (mispredict) flushPc <= addrVec[headReg];
    end
  end

endmodule
